// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, fetch buffer entry type, FSM states and the PC legality helper
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {RUN, FAULT} fetch_state_e;
  function automatic logic pc_legal(logic [PC_W-1:0] pc, logic [PC_W-1:0] limit);
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch entries (clk, rst, push, pop, flush, din -> full, empty, head); flush beats push
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  // e0 is always the head; e1 only matters when two entries are held
  always_comb begin
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    e0_d  = pop ? ((cnt_q == 2'd2) ? e1_q : din) : ((cnt_q == 2'd0) ? din : e0_q);
    e1_d  = push ? din : e1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == 2'd0;
  assign head  = e0_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem address, 2-entry fetch buffer to decode (valid/ready), redirects and sticky PC fault
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault
);
  localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(MEM_WORDS * 4);
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic legal, pop, fetch_en, full, empty;
  fetch_entry_t head;
  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (fetch_en),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ('{pc: pc_q, instr: imem_instr}),
    .full (full),
    .empty(empty),
    .head (head)
  );
  // a redirect decides the next state from its target, so an illegal target faults directly
  always_comb begin
    legal    = pc_legal(pc_q, PC_LIMIT);
    pop      = !empty && out_ready;
    fetch_en = (state_q == RUN) && legal && (!full || pop) && !redirect_valid;
    state_d  = redirect_valid ? (pc_legal(redirect_pc, PC_LIMIT) ? RUN : FAULT) :
               ((state_q == RUN) && !legal) ? FAULT : state_q;
    pc_d     = redirect_valid ? redirect_pc : fetch_en ? pc_q + 32'd4 : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign imem_addr    = pc_q;
  assign out_valid    = !empty;
  assign out_instr    = empty ? '0 : head.instr;
  assign out_pc       = empty ? '0 : head.pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign fault        = state_q == FAULT;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plan plus randomized traffic checked against a queue-based model
module tb_instruction_fetch_unit;
  logic clk, rst, redirect_valid, out_ready, out_valid, fault;
  logic [31:0] imem_addr, imem_instr, redirect_pc, out_instr, out_pc, out_pc_plus4;
  logic [31:0] mem [64];
  int checks, errors;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t q[$];
  logic [31:0] mpc;
  bit mfault;

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fault(fault)
  );

  assign imem_instr = mem[imem_addr[7:2]];

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit legal(logic [31:0] pc);
    return pc[1:0] == 2'b00 && pc < 32'h100;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare against the model mid-cycle, then advance the model with this cycle's inputs
  task automatic step();
    bit pop, fetch;
    logic [31:0] epc;
    @(negedge clk);
    epc = q.size() != 0 ? q[0].pc : 32'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, q.size() != 0 ? q[0].instr : 32'h0);
    chk("out_pc_plus4", out_pc_plus4, epc + 32'd4);
    chk("imem_addr", imem_addr, mpc);
    chk("fault", {31'b0, fault}, {31'b0, mfault});
    if (rst) begin
      mpc = 0; q.delete(); mfault = 0;
    end else if (redirect_valid) begin
      q.delete(); mpc = redirect_pc; mfault = !legal(redirect_pc);
    end else begin
      pop = q.size() != 0 && out_ready;
      fetch = !mfault && legal(mpc) && (q.size() < 2 || pop);
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back('{mpc, mem[mpc[7:2]]});
        mpc += 4;
      end else if (!mfault && !legal(mpc)) mfault = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; redirect_valid = 0; out_ready = 0;
    step();
    rst = 0;
  endtask

  initial begin
    logic [31:0] last;
    int r;
    checks = 0; errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2010_0004;
    mem[1] = 32'h2008_0001;
    mem[13] = 32'h2011_001C;
    rst = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    @(posedge clk); #1;
    mpc = 0; q.delete(); mfault = 0;

    // 1: streaming with no gaps
    do_reset();
    out_ready = 1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_plus4", out_pc_plus4, 32'h4);
    step();
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_instr0", out_instr, 32'h2010_0004);
    step();
    chk("t1_pc4", out_pc, 32'h4);
    chk("t1_instr4", out_instr, 32'h2008_0001);
    for (int i = 2; i < 6; i++) begin
      step();
      chk("t1_stream", out_pc, 32'(i * 4));
    end

    // 2: backpressure holds buffer and PC
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("t2_addr", imem_addr, 32'h8);
    chk("t2_head", out_pc, 32'h0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_drain", out_pc, 32'(i * 4));
      step();
    end

    // 3: redirect mid-stream
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    chk("t3_addr", imem_addr, 32'h10);
    redirect_valid = 1; redirect_pc = 32'h34;
    step();
    redirect_valid = 0;
    chk("t3_gap", {31'b0, out_valid}, 32'd0);
    step();
    chk("t3_pc", out_pc, 32'h34);
    chk("t3_instr", out_instr, 32'h2011_001C);
    step();
    chk("t3_next", out_pc, 32'h38);

    // 4: run off the end of memory, then recover
    do_reset();
    out_ready = 1;
    last = 32'hDEAD;
    for (int i = 0; i < 80; i++) begin
      if (fault) break;
      if (out_valid) last = out_pc;
      step();
    end
    chk("t4_last", last, 32'hFC);
    chk("t4_fault", {31'b0, fault}, 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1; redirect_pc = 32'h0;
    step();
    redirect_valid = 0;
    chk("t4_clear", {31'b0, fault}, 32'd0);
    step();
    chk("t4_pc0", out_pc, 32'h0);

    // 5: misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h6;
    step();
    redirect_valid = 0;
    chk("t5_fault", {31'b0, fault}, 32'd1);
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("t5_hold", imem_addr, 32'h6);

    // 6: reset with a full buffer
    do_reset();
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    step();
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_fault", {31'b0, fault}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    rst = 0; out_ready = 1;
    step();
    chk("t6_pc0", out_pc, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(99) == 0;
      out_ready = $urandom_range(3) != 0;
      redirect_valid = $urandom_range(14) == 0;
      r = $urandom_range(9);
      redirect_pc = r == 0 ? 32'h100 : r == 1 ? 32'h6 : r == 2 ? 32'hF8 :
                    {24'h0, 6'($urandom_range(63)), 2'b00};
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the program counter, drives the word address to the combinational instruction memory, and captures each returned word with its PC into a 2-entry buffer. Presents fetched instructions to decode over a valid/ready handshake, accepts branch/jump redirects, and flags out-of-range or misaligned PCs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
MEM_WORDS, 64, instruction memory depth in 32-bit words; legal PC range is 0 to MEM_WORDS*4-4.
BUF_DEPTH, 2, fetch buffer entries. Fixed at 2; other values are not supported.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; always equals the current PC.
imem_instr  input  32  instruction word returned combinationally in the same cycle.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  target byte address.
out_valid  output  1  buffer head is valid.
out_ready  input  1  decode accepts the head.
out_instr  output  32  head instruction.
out_pc  output  32  head PC.
out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
fault  output  1  sticky flag for a PC out of range or misaligned.

Behaviour:
- Reset (synchronous, any cycle, including mid-stream): pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=4, fault=0, state=RUN.
- States: RUN and FAULT.
- fetch_en = (state==RUN) & pc legal & (buffer not full, or a pop occurs this cycle) & !redirect_valid.
- pc legal: pc[1:0]==0 and pc < MEM_WORDS*4.
- RUN, fetch_en=1:
  - {pc, imem_instr} is pushed at the clock edge.
  - pc <= pc+4.
- Latency: an entry fetched in cycle N is out_valid in cycle N+1. After reset deassertion, the first fetch is in cycle 0 and out_valid=1 in cycle 1.
- Pop: out_valid & out_ready. out_* always show the head entry and are stable while out_valid=1 and out_ready=0.
- Full buffer with no pop: no fetch; pc holds; imem_addr holds.
- Full buffer with a pop in the same cycle: push and pop both occur; count stays at 2.
- Redirect, asserted in cycle N:
  - At the edge, the buffer is flushed and pc <= redirect_pc.
  - The cycle-N fetch is discarded.
  - out_valid=0 in cycle N+1, the target is fetched in N+1, and out_valid=1 with out_pc=target in N+2.
  - A pop handshake in cycle N still counts as accepted.
  - Redirect has priority over push and over backpressure.
- Illegal pc in RUN (no redirect):
  - Go to FAULT and set fault=1 at the edge.
  - No fetch is issued; pc holds the offending value.
  - Entries already buffered still drain normally.
- FAULT:
  - No fetches; fault stays 1.
  - A redirect to a legal target clears fault and returns to RUN; the target is fetched next cycle.
  - A redirect to an illegal target keeps FAULT with the new pc.
- Arithmetic: PC math is 32-bit modulo 2^32. Sequential fetch cannot wrap past 2^32, because the range check faults first. Memory index is pc>>2.

Decomposition:
- Package fetch_pkg:
  - PC_W=32 and INSTR_W=32.
  - fetch_entry_t packed struct {pc, instr}.
  - fetch_state_e {RUN, FAULT}.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, full, empty and head outputs. Flush has priority over push.
- Top level contains the PC register, the legality check, and the FSM.

Test Plan:
1. Reset then out_ready=1 with the program image loaded: cycle 1 shows out_pc=0x0, out_instr=0x20100004; cycle 2 shows out_pc=0x4, out_instr=0x20080001; one instruction per cycle with no gaps.
2. out_ready=0 from cycle 1 for 5 cycles: buffer holds PCs 0x0 and 0x4; imem_addr stays at 0x8; out_pc stays 0x0. Then out_ready=1: 0x0, 0x4, 0x8 are delivered back-to-back with none lost or duplicated.
3. While streaming at pc=0x10, redirect_valid=1 with redirect_pc=0x34: next cycle out_valid=0. The cycle after shows out_pc=0x34, out_instr=0x2011001C. No entry with PC 0x10 or 0x14 appears after the redirect.
4. Free-run with MEM_WORDS=64 and no redirects: the last delivered out_pc=0xFC, then fault=1 with pc=0x100 and out_valid=0. Then redirect_pc=0x0: fault clears, and out_pc=0x0 appears 2 cycles later.
5. redirect_pc=0x6 (misaligned): fault=1 the following cycle; no fetch issued; out_valid=0.
6. With a full buffer, assert rst for one cycle: next cycle out_valid=0, fault=0, imem_addr=RESET_PC. Deassert: out_pc=0x0 one cycle after the first fetch.
